// File: rtl/serial_pkg.sv
// Shared FSM encoding and sizing helpers
// for the bit-serial subtractor.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// Combinational 1-bit full subtractor cell,
// port-compatible in style with the full-adder cell.
module serial_sub_fs (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~i_a & i_bin) | (i_b & i_bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial A - B subtractor: parallel load, LSB-first
// processing through one full-subtractor cell.
module serial_sub
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_q;
    logic             borrow;
    logic             bout_q;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bo;

    serial_sub_fs u_fs (
        .i_a    (a_sr[0]),
        .i_b    (b_sr[0]),
        .i_bin  (borrow),
        .o_diff (d),
        .o_bout (bo)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (i_start) state_nx = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            diff_q  <= '0;
            borrow  <= 1'b0;
            bout_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && i_start) begin
                a_sr   <= i_a;
                b_sr   <= i_b;
                borrow <= 1'b0;
                cnt    <= '0;
            end else if (state == ST_RUN) begin
                a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                diff_sr <= {d, diff_sr[WIDTH-1:1]};
                borrow  <= bo;
                cnt     <= cnt + 1'b1;
                // Publish on the MSB cycle so results hold through the next RUN
                if (cnt == LAST) begin
                    diff_q <= {d, diff_sr[WIDTH-1:1]};
                    bout_q <= bo;
                end
            end
        end
    end

    assign o_busy = (state != ST_IDLE);
    assign o_done = (state == ST_DONE);
    assign o_diff = diff_q;
    assign o_bout = bout_q;

endmodule
